add3_chunk_sequencer: RTL and testbench



---
 rtl/add3_chunk_sequencer.sv | 133 +++++++++++++
 tb/tb_add3_chunk_sequencer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add3_chunk_sequencer.sv
// Chunk-serial three-operand adder: LSB chunk first, one registered sum per chunk, then a carry beat.
// Optional fixed-length termination via num_beats: define ADD3_CHUNK_SEQUENCER_FIXED_LEN_EN.
//
// state | meaning
// IDLE  | no operation open
// RUN   | operation open, more chunks expected
// FLUSH | all chunks consumed, carry beat pending
module add3_chunk_sequencer #(
    parameter int N          = 32,
    parameter int MAX_BEATS  = 64,
    localparam int CW        = $clog2(MAX_BEATS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    input  logic [N-1:0]  in_c,
    input  logic          in_last,
`ifdef ADD3_CHUNK_SEQUENCER_FIXED_LEN_EN
    input  logic [CW-1:0] num_beats,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          out_last,
    output logic          busy,
    output logic          len_err
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

    state_t         state_q;
    logic [1:0]     carry_q;
    logic [CW-1:0]  beat_q;
    logic           out_valid_q;
    logic           out_last_q;
    logic [N-1:0]   out_data_q;
    logic           len_err_q;

    logic           out_free;
    logic           accept;
    logic [1:0]     carry_in;
    logic [N+1:0]   sum_d;
    logic [CW-1:0]  beat_d;
    logic           term_d;
    logic           len_err_d;

`ifdef ADD3_CHUNK_SEQUENCER_FIXED_LEN_EN
    logic [CW-1:0]  target_q;
    logic [CW-1:0]  target_d;
    logic           over_q;
    logic           over_d;
`endif

    always_comb begin
        out_free = !out_valid_q || out_ready;
        in_ready = (state_q != FLUSH) && out_free;
        accept   = in_valid && in_ready;
        carry_in = (state_q == IDLE) ? 2'd0 : carry_q;
        // Three N-bit chunks plus a carry of at most 2 never exceed N+2 bits.
        sum_d    = (N+2)'(in_a) + (N+2)'(in_b) + (N+2)'(in_c) + (N+2)'(carry_in);
        beat_d   = (state_q == IDLE) ? CW'(1) : beat_q + CW'(1);
`ifdef ADD3_CHUNK_SEQUENCER_FIXED_LEN_EN
        if (state_q == IDLE) begin
            over_d = (num_beats > MAX_CNT);
            if (num_beats == '0)
                target_d = CW'(1);
            else if (over_d)
                target_d = MAX_CNT;
            else
                target_d = num_beats;
        end else begin
            target_d = target_q;
            over_d   = over_q;
        end
        term_d    = (beat_d == target_d);
        len_err_d = term_d && over_d;
`else
        term_d    = in_last || (beat_d == MAX_CNT);
        len_err_d = !in_last && (beat_d == MAX_CNT);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            carry_q     <= 2'd0;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            len_err_q   <= 1'b0;
`ifdef ADD3_CHUNK_SEQUENCER_FIXED_LEN_EN
            target_q    <= '0;
            over_q      <= 1'b0;
`endif
        end else begin
            len_err_q <= 1'b0;
            if (accept) begin
                out_data_q  <= sum_d[N-1:0];
                out_valid_q <= 1'b1;
                out_last_q  <= 1'b0;
                carry_q     <= sum_d[N+1:N];
                beat_q      <= beat_d;
                state_q     <= term_d ? FLUSH : RUN;
                len_err_q   <= len_err_d;
`ifdef ADD3_CHUNK_SEQUENCER_FIXED_LEN_EN
                target_q    <= target_d;
                over_q      <= over_d;
`endif
            end else if (state_q == FLUSH && out_free) begin
                out_data_q  <= N'(carry_q);
                out_last_q  <= 1'b1;
                out_valid_q <= 1'b1;
                state_q     <= IDLE;
                carry_q     <= 2'd0;
            end else if (out_free) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_add3_chunk_sequencer.sv
// Bench for add3_chunk_sequencer (N=8, MAX_BEATS=4) against a big-integer reference model.
module tb_add3_chunk_sequencer;

    localparam int N         = 8;
    localparam int MAX_BEATS = 4;
    localparam int CW        = $clog2(MAX_BEATS + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_a = '0, in_b = '0, in_c = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N-1:0]  out_data;
    logic          out_last;
    logic          busy;
    logic          len_err;
    logic [CW-1:0] num_beats_s = '0;

    add3_chunk_sequencer #(.N(N), .MAX_BEATS(MAX_BEATS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_last   (in_last),
`ifdef ADD3_CHUNK_SEQUENCER_FIXED_LEN_EN
        .num_beats (num_beats_s),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: whole-operation sum as a big integer.
    logic [63:0]  acc_sum = '0;
    int           k_open = 0;
    int           tgt = 1;
    bit           over = 0;
    bit           exp_le = 0;
    logic [N-1:0] exp_d[$];
    bit           exp_l[$];
    logic [N-1:0] obs_d[$];
    bit           obs_l[$];
    bit           prev_hold = 0;
    logic [N-1:0] prev_d = '0;
    bit           prev_l = 0;
    int           le_seen = 0;
    int           stall = 0;

    task automatic model_accept(input logic [N-1:0] a, b, c, input bit last, input logic [CW-1:0] nb);
        bit term, err;
        if (k_open == 0) begin
            acc_sum = '0;
            over = (int'(nb) > MAX_BEATS);
            if (nb == '0) tgt = 1;
            else if (over) tgt = MAX_BEATS;
            else tgt = int'(nb);
        end
        acc_sum = acc_sum + ((64'(a) + 64'(b) + 64'(c)) << (N * k_open));
        k_open++;
        exp_d.push_back(N'(acc_sum >> (N * (k_open - 1))));
        exp_l.push_back(1'b0);
`ifdef ADD3_CHUNK_SEQUENCER_FIXED_LEN_EN
        term = (k_open == tgt);
        err  = term && over;
`else
        term = last || (k_open == MAX_BEATS);
        err  = !last && (k_open == MAX_BEATS);
`endif
        if (term) begin
            exp_d.push_back(N'(acc_sum >> (N * k_open)));
            exp_l.push_back(1'b1);
            k_open = 0;
        end
        exp_le = err;
    endtask

    // One cycle, entered and left at a falling edge.
    task automatic cyc(input bit v, input logic [N-1:0] a, b, c, input bit last,
                       input logic [CW-1:0] nb, input bit ordy, output bit acc_o);
        logic [N-1:0] ed;
        bit el;
        in_valid = v; in_a = a; in_b = b; in_c = c; in_last = last;
        num_beats_s = nb; out_ready = ordy;
        #1;
        if (prev_hold) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l) begin
                miscompares++;
                $display("FAIL hold_stable got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                         out_valid, out_data, out_last, prev_d, prev_l);
            end
        end
        vectors++;
        if (len_err !== exp_le) begin
            miscompares++;
            $display("FAIL len_err got %0b want %0b", len_err, exp_le);
        end
        if (len_err === 1'b1) le_seen++;
        if (k_open > 0) begin
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_open got %0b want 1", busy);
            end
        end
        if (out_valid === 1'b1 && out_last === 1'b1) begin
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_after_carry got %0b want 0", busy);
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b0) begin
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL in_ready_held got %0b want 0", in_ready);
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            vectors++;
            if (exp_d.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_out got %h/%0b want none", out_data, out_last);
            end else begin
                ed = exp_d.pop_front();
                el = exp_l.pop_front();
                if (out_data !== ed || out_last !== el) begin
                    miscompares++;
                    $display("FAIL out_beat got %h/%0b want %h/%0b", out_data, out_last, ed, el);
                end
            end
            obs_d.push_back(out_data);
            obs_l.push_back(out_last);
        end
        prev_hold = (out_valid === 1'b1) && !ordy;
        prev_d = out_data;
        prev_l = out_last;
        exp_le = 1'b0;
        acc_o = v && (in_ready === 1'b1);
        if (acc_o) model_accept(a, b, c, last, nb);
        @(negedge clk);
    endtask

    task automatic send_chunk(input logic [N-1:0] a, b, c, input bit last,
                              input logic [CW-1:0] nb, input bit rnd);
        bit acc_o;
        int n;
        acc_o = 1'b0;
        n = 0;
        while (!acc_o && n < 200) begin
            bit v, r;
            v = rnd ? ($urandom % 4 != 0) : 1'b1;
            if (stall > 0) begin
                r = 1'b0;
                stall--;
            end else begin
                r = rnd ? ($urandom % 4 != 0) : 1'b1;
            end
            cyc(v, a, b, c, last, nb, r, acc_o);
            n++;
        end
        if (!acc_o) begin
            miscompares++;
            $display("FAIL accept_timeout got no accept in %0d cycles want accept", n);
        end
    endtask

    task automatic drain(input int ncyc);
        bit acc_o;
        for (int i = 0; i < ncyc; i++) cyc(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, acc_o);
        vectors++;
        if (exp_d.size() != 0) begin
            miscompares++;
            $display("FAIL leftover got %0d pending want 0", exp_d.size());
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        out_ready = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 ||
            out_data !== '0 || len_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got v=%0b busy=%0b l=%0b d=%h le=%0b want all 0",
                     out_valid, busy, out_last, out_data, len_err);
        end
        reset = 1'b0;
        exp_d.delete(); exp_l.delete();
        k_open = 0; acc_sum = '0; exp_le = 1'b0; prev_hold = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_single();
        logic [N-1:0] wd[$];
        bit wl[$];
        wd = '{8'hFD, 8'h02};
        wl = '{1'b0, 1'b1};
        obs_d.delete(); obs_l.delete();
        send_chunk(8'hFF, 8'hFF, 8'hFF, 1'b1, CW'(1), 1'b0);
        drain(4);
        vectors++;
        if (obs_d.size() != wd.size()) begin
            miscompares++;
            $display("FAIL single_count got %0d want %0d", obs_d.size(), wd.size());
        end else begin
            for (int i = 0; i < wd.size(); i++) begin
                vectors++;
                if (obs_d[i] !== wd[i] || obs_l[i] !== wl[i]) begin
                    miscompares++;
                    $display("FAIL single_beat%0d got %h/%0b want %h/%0b", i, obs_d[i], obs_l[i], wd[i], wl[i]);
                end
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_busy got %0b want 0", busy);
        end
    endtask

    task automatic test_three_chunks();
        logic [N-1:0] wd[$];
        bit wl[$];
        wd = '{8'h00, 8'h00, 8'h01, 8'h00};
        wl = '{1'b0, 1'b0, 1'b0, 1'b1};
        obs_d.delete(); obs_l.delete();
        send_chunk(8'hFF, 8'h01, 8'h00, 1'b0, CW'(3), 1'b0);
        send_chunk(8'hFF, 8'h00, 8'h00, 1'b0, CW'(3), 1'b0);
        send_chunk(8'h00, 8'h00, 8'h00, 1'b1, CW'(3), 1'b0);
        drain(4);
        vectors++;
        if (obs_d.size() != wd.size()) begin
            miscompares++;
            $display("FAIL three_count got %0d want %0d", obs_d.size(), wd.size());
        end else begin
            for (int i = 0; i < wd.size(); i++) begin
                vectors++;
                if (obs_d[i] !== wd[i] || obs_l[i] !== wl[i]) begin
                    miscompares++;
                    $display("FAIL three_beat%0d got %h/%0b want %h/%0b", i, obs_d[i], obs_l[i], wd[i], wl[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        obs_d.delete(); obs_l.delete();
        for (int i = 0; i < 4; i++) begin
            send_chunk(N'($urandom), N'($urandom), N'($urandom), i == 3, CW'(4), 1'b0);
            if (i == 1) stall = 5;
        end
        drain(10);
        vectors++;
        if (obs_d.size() != 5) begin
            miscompares++;
            $display("FAIL bp_count got %0d want 5", obs_d.size());
        end
    endtask

    task automatic test_force_max();
        logic [N-1:0] wd[$];
        bit wl[$];
        wd = '{8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h03};
        wl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        obs_d.delete(); obs_l.delete();
        le_seen = 0;
        for (int i = 0; i < 4; i++) send_chunk(8'hFF, 8'hFF, 8'hFF, 1'b0, CW'(MAX_BEATS + 1), 1'b0);
        send_chunk(8'h01, 8'h01, 8'h01, 1'b0, CW'(MAX_BEATS + 1), 1'b0);
        drain(6);
        vectors++;
        if (le_seen != 1) begin
            miscompares++;
            $display("FAIL len_err_pulses got %0d want 1", le_seen);
        end
        vectors++;
        if (obs_d.size() != wd.size()) begin
            miscompares++;
            $display("FAIL force_count got %0d want %0d", obs_d.size(), wd.size());
        end else begin
            for (int i = 0; i < wd.size(); i++) begin
                vectors++;
                if (obs_d[i] !== wd[i] || obs_l[i] !== wl[i]) begin
                    miscompares++;
                    $display("FAIL force_beat%0d got %h/%0b want %h/%0b", i, obs_d[i], obs_l[i], wd[i], wl[i]);
                end
            end
        end
        do_reset();
    endtask

    task automatic test_reset_mid_op();
        obs_d.delete(); obs_l.delete();
        send_chunk(8'hFF, 8'hFF, 8'hFF, 1'b0, CW'(4), 1'b0);
        send_chunk(8'hFF, 8'hFF, 8'hFF, 1'b0, CW'(4), 1'b0);
        do_reset();
        obs_d.delete(); obs_l.delete();
        send_chunk(8'h01, 8'h01, 8'h01, 1'b1, CW'(1), 1'b0);
        drain(4);
        vectors++;
        if (obs_d.size() != 2) begin
            miscompares++;
            $display("FAIL rst_count got %0d want 2", obs_d.size());
        end else begin
            vectors++;
            if (obs_d[0] !== 8'h03 || obs_l[0] !== 1'b0 || obs_d[1] !== 8'h00 || obs_l[1] !== 1'b1) begin
                miscompares++;
                $display("FAIL rst_beats got %h/%0b %h/%0b want 03/0 00/1",
                         obs_d[0], obs_l[0], obs_d[1], obs_l[1]);
            end
        end
    endtask

    task automatic test_back_to_back_random();
        for (int op = 0; op < 60; op++) begin
            int  len;
            bit  use_last;
            logic [CW-1:0] nb;
            len = $urandom_range(1, MAX_BEATS);
            use_last = ($urandom % 4 != 0);
            nb = use_last ? CW'(len) : CW'($urandom_range(0, (1 << CW) - 1));
            for (int i = 0; i < len; i++)
                send_chunk(N'($urandom), N'($urandom), N'($urandom),
                           use_last && (i == len - 1), nb, 1'b1);
        end
        drain(12);
        do_reset();
    endtask

`ifdef ADD3_CHUNK_SEQUENCER_FIXED_LEN_EN
    task automatic test_fixed_len();
        obs_d.delete(); obs_l.delete();
        for (int i = 0; i < 3; i++) send_chunk(N'($urandom), N'($urandom), N'($urandom), 1'b0, CW'(3), 1'b0);
        drain(4);
        vectors++;
        if (obs_d.size() != 4 || obs_l[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL fixed_len got %0d beats want 4 ending in last", obs_d.size());
        end
        obs_d.delete(); obs_l.delete();
        send_chunk(8'h10, 8'h20, 8'h30, 1'b0, CW'(0), 1'b0);
        drain(4);
        vectors++;
        if (obs_d.size() != 2) begin
            miscompares++;
            $display("FAIL fixed_zero got %0d beats want 2", obs_d.size());
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_three_chunks();
        test_backpressure();
        test_force_max();
        test_reset_mid_op();
        test_back_to_back_random();
`ifdef ADD3_CHUNK_SEQUENCER_FIXED_LEN_EN
        test_fixed_len();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
